// File: rtl/vmem_pkg.sv
// vmem_pkg: shared types, RGB565 field positions and the 565->888 expansion helper
package vmem_pkg;
  typedef logic page_t;
  typedef enum logic [1:0] {IDLE, FETCH, DONE} fetch_state_t;
  localparam int R_HI = 15, R_LO = 11, G_HI = 10, G_LO = 5, B_HI = 4, B_LO = 0;
  // Replicate the top bits into the low bits so full-scale 565 maps to 0xFF
  function automatic logic [23:0] rgb565_expand(input logic [15:0] h);
    return {h[R_HI:R_LO], h[R_HI -: 3], h[G_HI:G_LO], h[G_HI -: 2], h[B_HI:B_LO], h[B_HI -: 3]};
  endfunction
endpackage

// File: rtl/vmem_fifo.sv
// vmem_fifo: first-word-fall-through word FIFO with synchronous flush
module vmem_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push && count != (PW+1)'(DEPTH);
  assign do_pop = pop && count != '0;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + PW'(do_push);
      rp <= rp + PW'(do_pop);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/vmem_fb.sv
// vmem_fb: two-page framebuffer shared by a CPU port and a prefetching RGB scanout engine
module vmem_fb
  import vmem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int FRAME_WORDS = 38400,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic [31:0]       cpu_rdata,
  input  logic              mode,
  input  logic              flip_req,
  output logic              flip_done,
  input  logic              pix_start,
  input  logic              pix_ready,
  output logic              pix_valid,
  output logic [7:0]        R,
  output logic [7:0]        G,
  output logic [7:0]        B,
  output logic              underflow
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FCW = ADDR_W + 1;
  logic [31:0] mem [2**(ADDR_W+1)];
  logic [31:0] mem_q, head;
  logic [15:0] half;
  logic [ADDR_W:0] rd_addr;
  logic [FCW-1:0] fcount;
  logic [CW-1:0] count;
  fetch_state_t state, state_n;
  page_t disp_page;
  logic flip_pend, flip, sc_claim, sc_pend, grant, ack_rd, mode_r, hi, take, pop;
  // Reserve FIFO space for the read still in flight so a push can never overflow
  assign sc_claim = state == FETCH && !pix_start && ({1'b0, count} + (CW+1)'(sc_pend)) < (CW+1)'(FIFO_DEPTH / 2);
  assign grant = reset && cpu_req && !sc_claim && !cpu_ack;
  assign flip = pix_start && (flip_pend || flip_req);
  assign flip_done = reset && flip;
  assign rd_addr = sc_claim ? {disp_page, fcount[ADDR_W-1:0]} : {~disp_page, cpu_addr};
  assign state_n = pix_start ? FETCH : (sc_claim && fcount == FCW'(FRAME_WORDS - 1)) ? DONE : state;
  assign cpu_rdata = ack_rd ? mem_q : '0;
  assign pix_valid = count != '0;
  assign take = pix_ready && pix_valid;
  assign pop = take && (!mode_r || hi);
  assign half = hi ? head[31:16] : head[15:0];
  assign {R, G, B} = !pix_valid ? 24'd0 : mode_r ? rgb565_expand(half) : head[31:8];
  always_ff @(posedge clk) begin
    if (grant && cpu_we) mem[rd_addr] <= cpu_wdata;
    mem_q <= mem[rd_addr];
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      disp_page <= 1'b0;
      flip_pend <= 1'b0;
      fcount <= '0;
      sc_pend <= 1'b0;
      cpu_ack <= 1'b0;
      ack_rd <= 1'b0;
      mode_r <= 1'b0;
      hi <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state <= state_n;
      disp_page <= disp_page ^ flip;
      flip_pend <= !pix_start && (flip_pend || flip_req);
      fcount <= pix_start ? '0 : fcount + FCW'(sc_claim);
      sc_pend <= sc_claim;
      cpu_ack <= grant;
      ack_rd <= grant && !cpu_we;
      mode_r <= pix_start ? mode : mode_r;
      hi <= (pix_start || pop) ? 1'b0 : hi ^ take;
      underflow <= !pix_start && (underflow || (pix_ready && !pix_valid && (state == FETCH || (state == DONE && sc_pend))));
    end
  end
  vmem_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk(clk),
    .reset(reset),
    .flush(pix_start),
    .push(sc_pend),
    .pop(pop),
    .din(mem_q),
    .dout(head),
    .count(count)
  );
endmodule
